// File: rtl/cpu_mem_pkg.sv
// Types and default widths shared by the CPU core, the memory arbiter and the RAM model.
package cpu_mem_pkg;

    localparam int CPU_ADDR_W = 8;
    localparam int CPU_DATA_W = 32;

    // Which port is waiting for the read data coming back from the RAM.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        IF   = 2'd1,
        DATA = 2'd2
    } owner_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. req[0]/gnt[0] is the fetch port, req[1]/gnt[1] the data port.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // 1 = data port won the most recent contended cycle.
    logic last_win_reg;

    // Grants are masked while reset is held so nothing leaks out during reset.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            if (req == 2'b11) begin
                gnt = last_win_reg ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_win_reg <= 1'b1;
        end else if (req == 2'b11) begin
            last_win_reg <= gnt[1];
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one synchronous single-port RAM between the fetch port and the load/store port,
// steering the one-cycle-late read data back to whichever port issued the read.
module cpu_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0]        gnt;
    owner_t            rd_owner_reg;
    logic [DATA_W-1:0] if_rdata_reg;
    logic [DATA_W-1:0] d_rdata_reg;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({d_req, if_req}),
        .gnt   (gnt)
    );

    assign if_gnt    = gnt[0];
    assign d_gnt     = gnt[1];
    assign mem_en    = |gnt;
    assign mem_we    = gnt[1] & d_we;
    assign mem_addr  = gnt[1] ? d_addr : if_addr;
    assign mem_wdata = gnt[1] ? d_wdata : '0;

    // Each port sees live RAM data on its return cycle and a held copy otherwise.
    assign if_rvalid = (rd_owner_reg == IF);
    assign d_rvalid  = (rd_owner_reg == DATA);
    assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_reg;
    assign d_rdata   = d_rvalid ? mem_rdata : d_rdata_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_owner_reg <= NONE;
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
        end else begin
            if (rd_owner_reg == IF) begin
                if_rdata_reg <= mem_rdata;
            end
            if (rd_owner_reg == DATA) begin
                d_rdata_reg <= mem_rdata;
            end
            if (gnt[0]) begin
                rd_owner_reg <= IF;
            end else if (gnt[1] && !d_we) begin
                rd_owner_reg <= DATA;
            end else begin
                rd_owner_reg <= NONE;
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: a transaction-level model checks every cycle,
// and literal expectations pin the key scenarios.
module tb_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [7:0]  if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [7:0]  d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Write-first synchronous RAM.
    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: shadow memory, last contended winner, one pending return.
    logic [31:0] shadow [256];
    bit          m_last_data = 1'b1;
    int          pend_own = 0;
    logic [31:0] pend_data = '0;
    logic [31:0] exp_if_rd = '0;
    logic [31:0] exp_d_rd = '0;

    always @(negedge clk) begin
        bit g_if, g_d;
        if (!rst_n) begin
            chk("rst_if_gnt", {31'b0, if_gnt}, 0);
            chk("rst_d_gnt", {31'b0, d_gnt}, 0);
            chk("rst_if_rvalid", {31'b0, if_rvalid}, 0);
            chk("rst_d_rvalid", {31'b0, d_rvalid}, 0);
            chk("rst_mem_en", {31'b0, mem_en}, 0);
            chk("rst_mem_we", {31'b0, mem_we}, 0);
            chk("rst_if_rdata", if_rdata, 0);
            chk("rst_d_rdata", d_rdata, 0);
            m_last_data = 1'b1;
            pend_own    = 0;
            exp_if_rd   = '0;
            exp_d_rd    = '0;
        end else begin
            chk("if_rvalid", {31'b0, if_rvalid}, {31'b0, pend_own == 1});
            chk("d_rvalid", {31'b0, d_rvalid}, {31'b0, pend_own == 2});
            if (pend_own == 1) exp_if_rd = pend_data;
            if (pend_own == 2) exp_d_rd = pend_data;
            chk("if_rdata", if_rdata, exp_if_rd);
            chk("d_rdata", d_rdata, exp_d_rd);

            g_if = if_req && !d_req;
            g_d  = d_req && !if_req;
            if (if_req && d_req) begin
                g_if        = m_last_data;
                g_d         = !m_last_data;
                m_last_data = g_d;
            end
            chk("if_gnt", {31'b0, if_gnt}, {31'b0, g_if});
            chk("d_gnt", {31'b0, d_gnt}, {31'b0, g_d});
            chk("mem_en", {31'b0, mem_en}, {31'b0, g_if || g_d});
            chk("mem_we", {31'b0, mem_we}, {31'b0, g_d && d_we});
            if (g_if) chk("mem_addr_if", {24'b0, mem_addr}, {24'b0, if_addr});
            if (g_d) chk("mem_addr_d", {24'b0, mem_addr}, {24'b0, d_addr});
            if (g_d && d_we) chk("mem_wdata", mem_wdata, d_wdata);

            pend_own = 0;
            if (g_if) begin
                pend_own  = 1;
                pend_data = shadow[if_addr];
            end else if (g_d && !d_we) begin
                pend_own  = 2;
                pend_data = shadow[d_addr];
            end else if (g_d && d_we) begin
                shadow[d_addr] = d_wdata;
            end
        end
    end

    task automatic drive(input logic ir, input logic [7:0] ia, input logic dr,
                         input logic dw, input logic [7:0] da, input logic [31:0] wd);
        @(posedge clk);
        #1;
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = dw;
        d_addr  = da;
        d_wdata = wd;
        @(negedge clk);
        $display("vec ifr=%0d ia=%0d dr=%0d we=%0d da=%0d | ig=%0d dg=%0d ifv=%0d dv=%0d",
                 ir, ia, dr, dw, da, if_gnt, d_gnt, if_rvalid, d_rvalid);
    endtask

    initial begin
        logic [7:0] ia, da;
        logic       dh;
        int         wait_c;

        for (int i = 0; i < 256; i++) begin
            ram[i]    = 32'h10 + i;
            shadow[i] = 32'h10 + i;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fetch only
        drive(1, 0, 0, 0, 0, 0);
        chk("fetch0_gnt", {31'b0, if_gnt}, 1);
        drive(1, 1, 0, 0, 0, 0);
        chk("fetch1_rv", {31'b0, if_rvalid}, 1);
        chk("fetch1_data", if_rdata, 32'h10);
        drive(1, 2, 0, 0, 0, 0);
        chk("fetch2_data", if_rdata, 32'h11);
        drive(0, 0, 0, 0, 0, 0);
        chk("fetch3_data", if_rdata, 32'h12);
        chk("fetch3_drv", {31'b0, d_rvalid}, 0);

        // Contention: first contended cycle goes to IF
        drive(1, 3, 1, 0, 7, 0);
        chk("cont0_ifg", {31'b0, if_gnt}, 1);
        drive(1, 3, 1, 0, 7, 0);
        chk("cont1_dg", {31'b0, d_gnt}, 1);
        chk("cont1_ifdata", if_rdata, 32'h13);
        drive(1, 3, 1, 0, 7, 0);
        chk("cont2_ifg", {31'b0, if_gnt}, 1);
        chk("cont2_dv", {31'b0, d_rvalid}, 1);
        chk("cont2_ddata", d_rdata, 32'h17);
        drive(1, 3, 1, 0, 7, 0);
        chk("cont3_dg", {31'b0, d_gnt}, 1);

        // Store then load
        drive(0, 0, 1, 1, 5, 32'hDEADBEEF);
        chk("st_mem_we", {31'b0, mem_we}, 1);
        drive(0, 0, 1, 0, 5, 0);
        chk("st_no_dv", {31'b0, d_rvalid}, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("ld_dv", {31'b0, d_rvalid}, 1);
        chk("ld_data", d_rdata, 32'hDEADBEEF);
        chk("ld_ifv", {31'b0, if_rvalid}, 0);

        // Mixed stream: fetch continuously, data load every 3rd cycle
        ia = 8'd32;
        da = 8'd64;
        dh = 1'b0;
        wait_c = 0;
        for (int i = 0; i < 12; i++) begin
            logic dr;
            dr = (i % 3 == 0) || dh;
            if ((i % 3 == 0) && !dh) da = 8'(64 + i);
            drive(1, ia, dr, 0, da, 0);
            chk("mix_onehot", {31'b0, if_gnt & d_gnt}, 0);
            if (if_gnt) ia = ia + 8'd1;
            if (dr) begin
                if (d_gnt) begin
                    chk("mix_dwait", wait_c, 0 + (wait_c > 1 ? 99 : wait_c));
                    dh = 1'b0;
                    wait_c = 0;
                end else begin
                    dh = 1'b1;
                    wait_c++;
                    if (wait_c > 1) chk("mix_starve", wait_c, 1);
                end
            end
        end

        // Reset mid-read
        drive(0, 0, 1, 0, 9, 0);
        chk("rr_dg", {31'b0, d_gnt}, 1);
        @(posedge clk);
        #1;
        d_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rr_async_mem_en", {31'b0, mem_en}, 0);
        chk("rr_async_dv", {31'b0, d_rvalid}, 0);
        @(negedge clk);
        if_req  = 1'b1;
        if_addr = 8'd4;
        d_req   = 1'b1;
        d_addr  = 8'd9;
        #1;
        chk("rr_gated_ifg", {31'b0, if_gnt}, 0);
        chk("rr_gated_dg", {31'b0, d_gnt}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rr_first_ifg", {31'b0, if_gnt}, 1);
        chk("rr_first_dg", {31'b0, d_gnt}, 0);
        chk("rr_no_dv", {31'b0, d_rvalid}, 0);
        drive(1, 4, 1, 0, 9, 0);
        chk("rr_second_dg", {31'b0, d_gnt}, 1);
        chk("rr_ifdata", if_rdata, 32'h14);
        drive(0, 0, 0, 0, 0, 0);
        chk("rr_ddata", d_rdata, 32'h19);

        // Idle: nothing driven to RAM, read data held
        for (int i = 0; i < 10; i++) begin
            drive(0, 8'(i), 0, 1, 8'(i), 32'hFFFF_FFFF);
            chk("idle_mem_en", {31'b0, mem_en}, 0);
            chk("idle_mem_we", {31'b0, mem_we}, 0);
            chk("idle_ifdata", if_rdata, 32'h14);
            chk("idle_ddata", d_rdata, 32'h19);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
